mem_access_sequencer: RTL
=========================

// Module: mem_access_sequencer
// PURPOSE
//  Memory-stage access controller that sits between execute and the one-port byte-enabled RAM.
//  Accepts one load/store per handshake and decodes funct3 into size and sign.
//  Converts the byte address into word-aligned RAM accesses with byte enables and lane-shifted write data.
//  Splits word-crossing (misaligned) accesses into two RAM cycles, then merges, aligns and sign/zero-extends load data.
// PARAMETERS
//  ALLOW_MISALIGN  1  1: split word-crossing accesses; 0: every misaligned access is a fault with no RAM access
// PORTS
//  clk          in   1   rising-edge clock
//  rst          in   1   asynchronous, active-high reset
//  req_valid    in   1   request present
//  req_ready    out  1   sequencer can accept; transfer when req_valid & req_ready at clk edge
//  req_wren     in   1   1 = store, 0 = load
//  req_funct3   in   3   LB 000, LH 001, LW 010, LBU 100, LHU 101; stores use SB 000, SH 001, SW 010
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, LSB-justified
//  rsp_valid    out  1   one-cycle pulse: access complete
//  rsp_rdata    out  32  extended load data (0 for stores and faults)
//  rsp_fault    out  1   qualified by rsp_valid: illegal funct3, or misaligned access with ALLOW_MISALIGN=0
//  mem_addr     out  32  word-aligned RAM address; bits [1:0] always 0
//  mem_byteEn   out  4   RAM byte enables, used for reads and writes
//  mem_wren     out  1   RAM write enable
//  mem_wdata    out  32  lane-positioned write data
//  mem_rdata    in   32  RAM read data; valid the cycle after the address is presented
// BEHAVIOUR
//  Capture on accept
//   - Register wren, funct3, addr, wdata.
//   - off = addr[1:0]; nbytes = 1/2/4 for funct3[1:0] = 00/01/10; mask = 0001/0011/1111.
//   - split = (off + nbytes > 4).
//  States: IDLE, ACC0, ACC1, DONE, RESP
//  req_ready
//   - High in IDLE and RESP; low otherwise.
//   - Accepting in RESP goes directly to ACC0, giving back-to-back throughput.
//  Accept with illegal funct3
//   - Illegal loads: 011, 110, 111. Illegal stores: anything other than 000, 001, 010.
//   - Same for misaligned with ALLOW_MISALIGN=0; misaligned means half with addr[0]=1, or word with off != 0.
//   - Go to RESP with rsp_fault=1 and rsp_rdata=0. No RAM access.
//  ACC0
//   - mem_addr = {addr[31:2], 2'b00}.
//   - mem_byteEn = (mask << off)[3:0].
//   - mem_wdata = wdata << 8*off.
//   - mem_wren = wren.
//   - Next state: split ? ACC1 : DONE.
//  ACC1
//   - mem_addr = {addr[31:2], 2'b00} + 4, wrapping modulo 2^32.
//   - mem_byteEn = mask >> (4 - off).
//   - mem_wdata = wdata >> 8*(4 - off).
//   - mem_wren = wren.
//   - Latch mem_rdata (ACC0 result) as lo.
//   - Next state: DONE.
//  DONE
//   - mem_rdata is the last access result (hi if split, else lo).
//   - {hi, lo} >> 8*off, where hi = 0 when not split.
//   - Take bits [nbytes*8-1:0]; sign-extend for LB/LH, zero-extend for LBU/LHU; LW passes through.
//   - Register the result into rsp_rdata (0 for stores). Next state: RESP.
//  RESP: rsp_valid=1 for exactly one cycle.
//  mem_* outputs
//   - Decoded combinationally from state and captured registers.
//   - In IDLE, DONE and RESP: mem_wren=0, mem_byteEn=0, mem_addr=0, mem_wdata=0.
//  Latency (accept edge = T)
//   - Aligned access: rsp_valid in cycle T+3.
//   - Split access: rsp_valid in cycle T+4.
//   - Fault: rsp_valid in cycle T+1.
//  Reset (asynchronous, any state)
//   - State IDLE; rsp_valid=0, rsp_rdata=0, rsp_fault=0.
//   - mem_wren/mem_byteEn drop immediately.
//   - An in-flight split store is abandoned and its second half is not written.
//   - req_ready=1 after reset deasserts.
// TESTING
//  1. SW 0xDEADBEEF @0x10 -> ACC0 addr 0x10, byteEn 1111. Then LW @0x10 -> rsp_rdata 0xDEADBEEF at T+3, fault 0.
//  2. Word @0x10 = 0x80FF1234:
//     LB @0x13 -> byteEn 1000, rdata 0xFFFFFF80. LBU @0x13 -> 0x00000080. LH @0x12 -> 0xFFFF80FF.
//  3. SW 0x11223344 @0x0E:
//     ACC0 addr 0x0C, byteEn 1100, wdata 0x33440000.
//     ACC1 addr 0x10, byteEn 0011, wdata 0x00001122.
//     Then LW @0x0E -> 0x11223344 at T+4.
//  4. Word @0x0C = 0xAB000000, @0x10 = 0x000000CD: LH @0x0F -> 0xFFFFCDAB; LHU @0x0F -> 0x0000CDAB.
//  5. Faults, each -> rsp_valid+rsp_fault at T+1, mem_wren never high:
//     load funct3=011; store funct3=100; ALLOW_MISALIGN=0 with LW @0x0E.
//  6. Reset and throughput:
//     rst pulsed during ACC1 of split SW @0x0E -> mem_wren low same cycle; word @0x10 unchanged; req_ready=1 after release.
//     Back-to-back aligned requests held valid -> one rsp_valid every 3 cycles.

Source files
------------

// File: rtl/mem_access_sequencer_if.sv
// Bundle of request, response and RAM-side signals for the memory-access sequencer.
// The master side is the environment: it issues requests and provides the RAM.
// The slave side is the sequencer itself.
`timescale 1ns/1ps
interface mem_access_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wren;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [31:0] mem_addr;
  logic [3:0]  mem_byteEn;
  logic        mem_wren;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_wren, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
    input  mem_addr, mem_byteEn, mem_wren, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  req_valid, req_wren, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault,
    output mem_addr, mem_byteEn, mem_wren, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// Memory-stage load/store sequencer in front of a one-port byte-enabled RAM.
// Word-crossing accesses take two RAM cycles; load data is merged, aligned and extended.
//
// state | meaning
// IDLE  | waiting for a request
// ACC0  | first (or only) RAM access
// ACC1  | second RAM access of a word-crossing split; first read word latched
// DONE  | last read word available; response data registered
// RESP  | rsp_valid pulse; a new request may be accepted here
`timescale 1ns/1ps
module mem_access_sequencer #(
  parameter int ALLOW_MISALIGN = 1
) (
  input logic             clk,
  input logic             rst,
  mem_access_sequencer_if.slave bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ACC0 = 3'd1;
  localparam logic [2:0] ACC1 = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
  localparam logic [2:0] RESP = 3'd4;

  logic [2:0]  state;
  logic        wren_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] lo_q;
  logic [31:0] rdata_q;
  logic        fault_q;

  logic        accept;
  logic        req_illegal;
  logic        req_misalign;
  logic        req_fault;

  logic [1:0]  off;
  logic [3:0]  mask;
  logic [3:0]  nbytes;
  logic        split;
  logic [4:0]  sh0;
  logic [5:0]  sh1;
  logic [63:0] pair;
  logic [31:0] shifted;
  logic [31:0] load_result;

  assign bus.req_ready = (state == IDLE) || (state == RESP);
  assign accept        = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_fault = fault_q;

  // Classify the incoming request before it is accepted.
  always_comb begin
    if (bus.req_wren)
      req_illegal = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010});
    else
      req_illegal = bus.req_funct3 inside {3'b011, 3'b110, 3'b111};
    req_misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                   ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    req_fault = req_illegal || ((ALLOW_MISALIGN == 0) && req_misalign);
  end

  // Size, mask and split decode of the captured request.
  always_comb begin
    off = addr_q[1:0];
    case (funct3_q[1:0])
      2'b00:   begin mask = 4'b0001; nbytes = 4'd1; end
      2'b01:   begin mask = 4'b0011; nbytes = 4'd2; end
      default: begin mask = 4'b1111; nbytes = 4'd4; end
    endcase
    split = ({2'b00, off} + nbytes) > 4'd4;
    sh0   = {off, 3'b000};
    sh1   = 6'd32 - {1'b0, sh0};
  end

  // Merge the one or two read words, align to the byte offset and extend.
  always_comb begin
    pair    = split ? {bus.mem_rdata, lo_q} : {32'h0, bus.mem_rdata};
    shifted = 32'(pair >> sh0);
    case (funct3_q[1:0])
      2'b00:   load_result = funct3_q[2] ? {24'h0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_result = funct3_q[2] ? {16'h0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
      default: load_result = shifted;
    endcase
    if (wren_q)
      load_result = 32'h0;
  end

  // RAM-side outputs are driven only while an access is in progress.
  always_comb begin
    bus.mem_addr   = 32'h0;
    bus.mem_byteEn = 4'b0000;
    bus.mem_wren   = 1'b0;
    bus.mem_wdata  = 32'h0;
    case (state)
      ACC0: begin
        bus.mem_addr   = {addr_q[31:2], 2'b00};
        bus.mem_byteEn = 4'({4'b0000, mask} << off);
        bus.mem_wren   = wren_q;
        bus.mem_wdata  = wdata_q << sh0;
      end
      ACC1: begin
        bus.mem_addr   = {addr_q[31:2], 2'b00} + 32'd4;
        bus.mem_byteEn = mask >> (3'd4 - {1'b0, off});
        bus.mem_wren   = wren_q;
        bus.mem_wdata  = wdata_q >> sh1;
      end
      default: ;
    endcase
  end

  // Sequencer state, request capture and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wren_q   <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      lo_q     <= 32'h0;
      rdata_q  <= 32'h0;
      fault_q  <= 1'b0;
    end else begin
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            wren_q   <= bus.req_wren;
            funct3_q <= bus.req_funct3;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            if (req_fault) begin
              fault_q <= 1'b1;
              rdata_q <= 32'h0;
              state   <= RESP;
            end else begin
              state <= ACC0;
            end
          end else begin
            state <= IDLE;
          end
        end
        ACC0: state <= split ? ACC1 : DONE;
        ACC1: begin
          lo_q  <= bus.mem_rdata;
          state <= DONE;
        end
        DONE: begin
          rdata_q <= load_result;
          fault_q <= 1'b0;
          state   <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
